// File: rtl/exe_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the EXE stage.
// Holds the pipeline via stall_o while an operation is in flight; result is a one-cycle done_o pulse.
module exe_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] dataA_i,
    input  logic [XLEN-1:0] dataB_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  counter_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   acc_hi_q;
    logic [XLEN-1:0]   acc_lo_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_q;

    // Decode of the incoming op (used only on the accept cycle)
    logic            op_is_div;
    logic            op_signed;
    logic            op_rsvd;
    logic            div_by_zero;
    logic            div_overflow;
    logic            shortcut;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] short_result;

    assign op_is_div    = op_i[2];
    assign op_signed    = op_i[2] & ~op_i[0];
    assign op_rsvd      = (op_i[2:1] == 2'b01);
    assign div_by_zero  = op_is_div & (dataB_i == '0);
    assign div_overflow = op_signed & (dataA_i == {1'b1, {(XLEN-1){1'b0}}}) & (dataB_i == '1);
    assign shortcut     = op_rsvd | div_by_zero | div_overflow;

    assign a_neg = op_signed & dataA_i[XLEN-1];
    assign b_neg = op_signed & dataB_i[XLEN-1];
    assign a_mag = a_neg ? (~dataA_i + 1'b1) : dataA_i;
    assign b_mag = b_neg ? (~dataB_i + 1'b1) : dataB_i;

    // op_i[1] separates REM/REMU from DIV/DIVU
    always_comb begin
        short_result = '0;
        if (div_by_zero) begin
            short_result = op_i[1] ? dataA_i : '1;
        end else if (div_overflow) begin
            short_result = op_i[1] ? '0 : dataA_i;
        end
    end

    // One shift-add multiply step: {carry, hi, lo} shifted right by one
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_d;
    logic [XLEN-1:0] mul_lo_d;

    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi_d = mul_sum[XLEN:1];
    assign mul_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};

    // One restoring-divide step: hi is the partial remainder, lo shifts dividend out / quotient in
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_hi_d;
    logic [XLEN-1:0] div_lo_d;

    assign div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_diff[XLEN];
    assign div_hi_d  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_lo_d  = {acc_lo_q[XLEN-2:0], div_ge};

    // Result selection on the final iteration, with sign fix-up for signed divide
    logic [XLEN-1:0] final_result;

    always_comb begin
        final_result = '0;
        case (op_q)
            3'b000:         final_result = mul_lo_d;
            3'b001:         final_result = mul_hi_d;
            3'b100, 3'b101: final_result = neg_quo_q ? (~div_lo_d + 1'b1) : div_lo_d;
            3'b110, 3'b111: final_result = neg_rem_q ? (~div_hi_d + 1'b1) : div_hi_d;
            default:        final_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            op_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            b_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q <= op_i;
                        rd_q <= rd_i;
                        if (shortcut) begin
                            result_q <= short_result;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            counter_q <= CNT_W'(XLEN);
                            acc_hi_q  <= '0;
                            acc_lo_q  <= op_is_div ? a_mag : dataA_i;
                            b_q       <= op_is_div ? b_mag : dataB_i;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            state_q   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    counter_q <= counter_q - 1'b1;
                    acc_hi_q  <= op_q[2] ? div_hi_d : mul_hi_d;
                    acc_lo_q  <= op_q[2] ? div_lo_d : mul_lo_d;
                    if (counter_q == CNT_W'(1)) begin
                        result_q <= final_result;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o  = ((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_RUN);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Bench for exe_muldiv_unit: directed ops feed an expected queue, a negedge monitor pops and compares on done_o.
module tb_exe_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        flush_i;
    logic [2:0]  op_i;
    logic [31:0] dataA_i;
    logic [31:0] dataB_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    logic [36:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULHU = 3'b001, OP_RSV = 3'b010,
                           OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    exe_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .op_i     (op_i),
        .dataA_i  (dataA_i),
        .dataB_i  (dataB_i),
        .rd_i     (rd_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // monitor: every done_o pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(result_o), 64'hDEAD);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("result", 64'(result_o), 64'(e[31:0]));
                check("rd", 64'(rd_o), 64'(e[36:32]));
                check("stall_in_done", 64'(stall_o), 64'd0);
            end
        end
    end

    // driver: issue one op, then scramble the operand inputs and measure latency/stall cycles
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] expv, input int lat, input bit hold);
        int cyc;
        int stalls;
        @(negedge clk);
        op_i = op; dataA_i = a; dataB_i = b; rd_i = rd; start_i = 1'b1;
        exp_q.push_back({rd, expv});
        #1;
        stalls = stall_o ? 1 : 0;
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
        dataA_i = $urandom; dataB_i = $urandom; rd_i = 5'($urandom_range(0, 31));
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                dataA_i = $urandom; dataB_i = $urandom; op_i = 3'($urandom_range(0, 7));
            end
            if (stall_o) stalls++;
            if (done_o || cyc >= 40) break;
        end
        start_i = 1'b0;
        if (!done_o) exp_q.delete();
        check("latency", 64'(cyc), 64'(lat));
        check("stall_cycles", 64'(stalls), 64'(lat));
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
        dataA_i = '0; dataB_i = '0; rd_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_result", 64'(result_o), 64'd0);
        check("reset_rd", 64'(rd_o), 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);

        // multiply
        run_op(OP_MUL,   32'd7,        32'd6,        5'd5,  32'd42,       33, 1'b0);
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33, 1'b0);
        run_op(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000001, 33, 1'b0);
        run_op(OP_MULHU, 32'h80000000, 32'd2,        5'd8,  32'h00000001, 33, 1'b0);
        // divide
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33, 1'b0);
        run_op(OP_REM,   32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33, 1'b0);
        run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 33, 1'b0);
        run_op(OP_REM,   32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        33, 1'b0);
        run_op(OP_DIVU,  32'd100,      32'd7,        5'd13, 32'd14,       33, 1'b0);
        run_op(OP_REMU,  32'd100,      32'd7,        5'd14, 32'd2,        33, 1'b0);
        run_op(OP_DIVU,  32'hFFFFFFFF, 32'd1,        5'd15, 32'hFFFFFFFF, 33, 1'b0);
        // shortcuts
        run_op(OP_DIVU,  32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1,  1'b0);
        run_op(OP_REM,   32'd5,        32'd0,        5'd17, 32'd5,        1,  1'b0);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1,  1'b0);
        run_op(OP_REM,   32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1,  1'b0);
        run_op(OP_RSV,   32'd9,        32'd9,        5'd20, 32'd0,        1,  1'b0);
        run_op(OP_MUL,   32'd11,       32'd12,       5'd21, 32'd132,      33, 1'b0);

        // flush at RUN cycle 10: no done, result held, then a fresh op
        @(negedge clk);
        op_i = OP_MUL; dataA_i = 32'd5; dataB_i = 32'd5; rd_i = 5'd3; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (9) @(negedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        check("flush_stall", 64'(stall_o), 64'd0);
        check("flush_done", 64'(done_o), 64'd0);
        check("flush_result_held", 64'(result_o), 64'd132);
        repeat (40) @(negedge clk);
        run_op(OP_MUL,   32'd3,        32'd3,        5'd4,  32'd9,        33, 1'b0);

        // reset mid-RUN
        @(negedge clk);
        op_i = OP_MUL; dataA_i = 32'd4; dataB_i = 32'd4; rd_i = 5'd7; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_run_result", 64'(result_o), 64'd0);
        check("rst_run_rd", 64'(rd_o), 64'd0);
        check("rst_run_done", 64'(done_o), 64'd0);
        check("rst_run_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // start_i held high during RUN, then back-to-back ops
        run_op(OP_DIVU,  32'd1000,     32'd10,       5'd22, 32'd100,      33, 1'b1);
        run_op(OP_REMU,  32'd1001,     32'd10,       5'd23, 32'd1,        33, 1'b1);
        run_op(OP_MUL,   32'hFFFFFFFE, 32'd3,        5'd24, 32'hFFFFFFFA, 33, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
